// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staggered reset sequencer.
// The state enum, parameter defaults and the restart counter width live here.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_HOLD    = 2'd0,
        SEQ_STAGGER = 2'd1,
        SEQ_RUN     = 2'd2
    } seq_state_t;

    localparam int DEF_NUM_CH         = 4;
    localparam int DEF_HOLD_CYCLES    = 10;
    localparam int DEF_STAGGER_CYCLES = 4;
    localparam int DEF_SYNC_STAGES    = 2;
    localparam int RCNT_W             = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_trig.sv
// Multi-flop synchroniser bringing the asynchronous trigger into the clk domain.
module trig_sync
    import reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Holds all channel resets low for HOLD_CYCLES, then releases them one by one
// STAGGER_CYCLES apart; a synchronised trigger rising edge restarts the sequence.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              seq_busy,
    output logic              seq_done,
    output logic [RCNT_W-1:0] restart_cnt
);

    localparam int CNT_MAX = max2(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STG_LAST  =
        (STAGGER_CYCLES > 0) ? CNT_W'(STAGGER_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);
    // With one channel or no stagger everything releases on the hold boundary.
    localparam bit ALL_AT_ONCE = (NUM_CH == 1) || (STAGGER_CYCLES == 0);

    seq_state_t        r_state, w_nxt_state;
    logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
    logic [IDX_W-1:0]  r_idx, w_nxt_idx;
    logic [NUM_CH-1:0] r_ch, w_nxt_ch;
    logic              r_done, w_nxt_done;
    logic [RCNT_W-1:0] r_rcnt;
    logic              r_trig_d;
    logic              w_trig_s;
    logic              w_rise;

    trig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_trig_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (trigger),
        .o_sync  (w_trig_s)
    );

    // Edge detector flop resets to 0 so a trigger held high through reset counts once.
    assign w_rise = w_trig_s & ~r_trig_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SEQ_HOLD;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_ch     <= '0;
            r_done   <= 1'b0;
            r_rcnt   <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_idx    <= w_nxt_idx;
            r_ch     <= w_nxt_ch;
            r_done   <= w_nxt_done;
            r_trig_d <= w_trig_s;
            if (w_rise && (r_rcnt != '1)) begin
                r_rcnt <= r_rcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_idx   = r_idx;
        w_nxt_ch    = r_ch;
        w_nxt_done  = 1'b0;
        if (w_rise) begin
            w_nxt_state = SEQ_HOLD;
            w_nxt_cnt   = '0;
            w_nxt_idx   = '0;
            w_nxt_ch    = '0;
        end else begin
            case (r_state)
                SEQ_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_nxt_cnt = '0;
                        if (ALL_AT_ONCE) begin
                            w_nxt_ch    = '1;
                            w_nxt_state = SEQ_RUN;
                            w_nxt_done  = 1'b1;
                        end else begin
                            w_nxt_ch[0] = 1'b1;
                            w_nxt_idx   = IDX_W'(1);
                            w_nxt_state = SEQ_STAGGER;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                SEQ_STAGGER: begin
                    if (r_cnt == STG_LAST) begin
                        w_nxt_cnt       = '0;
                        w_nxt_ch[r_idx] = 1'b1;
                        if (r_idx == IDX_LAST) begin
                            w_nxt_state = SEQ_RUN;
                            w_nxt_done  = 1'b1;
                        end else begin
                            w_nxt_idx = r_idx + 1'b1;
                        end
                    end else begin
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ch_rst_n    = r_ch;
        seq_busy    = ~&r_ch;
        seq_done    = r_done;
        restart_cnt = r_rcnt;
    end

endmodule
